// File: rtl/bus_cycle_pkg.sv
// Shared state/mode encodings, default bus timing and a window helper for bus_cycle_gen.
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

  typedef enum logic {
    MODE_WRITE = 1'b0,
    MODE_READ  = 1'b1
  } mode_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_T_CYCLE   = 32;
  localparam int DEF_T_STB_ON  = 1;
  localparam int DEF_T_STB_OFF = 16;
  localparam int DEF_T_AD_HI   = 18;
  localparam int DEF_T_DRV_ON  = 6;
  localparam int DEF_T_DRV_OFF = 26;
  localparam int DEF_T_LATCH   = 15;
  localparam int DEF_T_GAP     = 4;

  // Half-open window test: lo <= k < hi.
  function automatic logic inWindow(input int k, input int lo, input int hi);
    return (k >= lo) && (k < hi);
  endfunction

endpackage

// File: rtl/bus_cycle_gen_phase_timer.sv
// Per-phase clock counter: clear has priority, counts while enabled and parks at terminal count.
module phase_timer #(
  parameter int T_CYCLE = 32,
  parameter int CNT_W   = (T_CYCLE > 1) ? $clog2(T_CYCLE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] countNext_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = (count_q == CNT_W'(T_CYCLE - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign countNext_o = count_d;

endmodule

// File: rtl/bus_cycle_gen.sv
// Address/data strobe generator for a multiplexed AD/CS/WR/RD peripheral bus.
// Define BUS_CYCLE_GAP_EN to add a T_GAP-clock GAP state after every transaction.
module bus_cycle_gen
  import bus_cycle_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int T_CYCLE   = DEF_T_CYCLE,
  parameter int T_STB_ON  = DEF_T_STB_ON,
  parameter int T_STB_OFF = DEF_T_STB_OFF,
  parameter int T_AD_HI   = DEF_T_AD_HI,
  parameter int T_DRV_ON  = DEF_T_DRV_ON,
  parameter int T_DRV_OFF = DEF_T_DRV_OFF,
  parameter int T_LATCH   = DEF_T_LATCH,
  parameter int T_GAP     = DEF_T_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              abort,
  input  logic [DATA_W-1:0] bus_in,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              CS,
  output logic              WR,
  output logic              RD,
  output logic              AD,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              LL
);

  localparam int CNT_W = (T_CYCLE > 1) ? $clog2(T_CYCLE) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_GAP - 1);

`ifdef BUS_CYCLE_GAP_EN
  localparam state_e AFTER_DATA = ST_GAP;
`else
  localparam state_e AFTER_DATA = ST_IDLE;
`endif

  state_e            state_q, state_d;
  mode_e             rw_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              tc, tmrClear, tmrEn, accept;
  int                kNow, kNext;
  logic              nAddr, nWrite, nRead, stbWin, drvWin;

  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, ad_q, ad_d;
  logic              oe_q, oe_d, ll_q, ll_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] busOut_q, busOut_d, rdData_q, rdData_d;

  // ack is the only output not taken from a flop: it must land in the same IDLE clock as req.
  assign accept = (state_q == ST_IDLE) && req;
  assign ack    = accept;

  assign tmrClear = (state_d != state_q);
  assign tmrEn    = (state_q != ST_IDLE);

  phase_timer #(
    .T_CYCLE (T_CYCLE),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (tmrClear),
    .en_i        (tmrEn),
    .count_o     (cnt),
    .countNext_o (cntNext),
    .tc_o        (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ADDR;
      ST_ADDR: begin
        if (abort)   state_d = ST_IDLE;
        else if (tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (abort)   state_d = ST_IDLE;
        else if (tc) state_d = AFTER_DATA;
      end
      ST_GAP:  if (abort || (cnt == GAP_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state/count so the flops show the window for the current k.
  assign kNow   = int'(cnt);
  assign kNext  = int'(cntNext);
  assign nAddr  = (state_d == ST_ADDR);
  assign nWrite = (state_d == ST_DATA) && (rw_q == MODE_WRITE);
  assign nRead  = (state_d == ST_DATA) && (rw_q == MODE_READ);
  assign stbWin = inWindow(kNext, T_STB_ON, T_STB_OFF);
  assign drvWin = inWindow(kNext, T_DRV_ON, T_DRV_OFF);

  always_comb begin
    cs_d     = ~(stbWin && (nAddr || nWrite || nRead));
    wr_d     = ~(stbWin && (nAddr || nWrite));
    rd_d     = ~(stbWin && nRead);
    ad_d     = ~(nAddr && (kNext < T_AD_HI));
    oe_d     = drvWin && (nAddr || nWrite);
    ll_d     = nRead && (kNext == T_LATCH);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_DATA) && tc && !abort;
    busOut_d = busOut_q;
    if (nAddr) begin
      busOut_d = accept ? addr : addr_q;
    end else if (nWrite) begin
      busOut_d = wdata_q;
    end
    rdData_d = rdData_q;
    if ((state_q == ST_DATA) && (rw_q == MODE_READ) && (kNow == T_LATCH) && !abort) begin
      rdData_d = bus_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rw_q     <= MODE_WRITE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      rd_q     <= 1'b1;
      ad_q     <= 1'b1;
      oe_q     <= 1'b0;
      ll_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      busOut_q <= '0;
      rdData_q <= '0;
    end else begin
      state_q  <= state_d;
      if (accept) begin
        rw_q    <= mode_e'(rw);
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ad_q     <= ad_d;
      oe_q     <= oe_d;
      ll_q     <= ll_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      busOut_q <= busOut_d;
      rdData_q <= rdData_d;
    end
  end

  assign CS      = cs_q;
  assign WR      = wr_q;
  assign RD      = rd_q;
  assign AD      = ad_q;
  assign bus_oe  = oe_q;
  assign LL      = ll_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_out = busOut_q;
  assign rd_data = rdData_q;

endmodule
